// File: rtl/multi_clock_divider.sv
// -----------------------------------------------------------------------------
// multi_clock_divider
//
// Divides a single source clock into CHANNELS independent outputs. Each
// channel is either a 50% duty square wave with period 2*f_act or a
// one-cycle tick with period f_act. A new factor or mode is only picked up
// at a terminal count, so no phase or pulse is ever shortened. in_sync
// restarts every running channel at the same edge.
//
// Ports
//   in_clk             source clock, all state changes on its rising edge
//   in_rst_n           asynchronous active-low reset
//   in_sync            one-cycle phase-align strobe shared by all channels
//   in_enable          per-channel run enable
//   in_mode            per-channel mode: 0 = square, 1 = tick
//   in_divider_factor  per-channel factor, channel i at [i*WIDTH +: WIDTH]
//   out_clk            per-channel divided output, straight from a register
//   out_active         per-channel running flag
// -----------------------------------------------------------------------------
module multi_clock_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      in_clk,
    input  logic                      in_rst_n,
    input  logic                      in_sync,
    input  logic [CHANNELS-1:0]       in_enable,
    input  logic [CHANNELS-1:0]       in_mode,
    input  logic [CHANNELS*WIDTH-1:0] in_divider_factor,
    output logic [CHANNELS-1:0]       out_clk,
    output logic [CHANNELS-1:0]       out_active
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] cnt_nxt;
        logic [WIDTH-1:0] f_act;
        logic [WIDTH-1:0] f_nxt;
        logic [WIDTH-1:0] f_in;
        logic             mode_act;
        logic             mode_nxt;
        logic             clk_q;
        logic             clk_nxt;
        logic             run_q;
        logic             run_nxt;
        logic             terminal;
        logic             update_pt;

        assign f_in     = in_divider_factor[i*WIDTH +: WIDTH];
        // f_act is never zero while counting, so f_act-1 cannot underflow
        // and the full 2^WIDTH-1 range counts without wrapping.
        assign terminal = (cnt == (f_act - ONE));
        // Tick mode may switch at any terminal count; square mode only at
        // the falling one so each low/high pair uses the same factor.
        assign update_pt = mode_act | clk_q;

        always_comb begin
            cnt_nxt  = cnt;
            f_nxt    = f_act;
            mode_nxt = mode_act;
            clk_nxt  = clk_q;
            run_nxt  = run_q;
            if (!in_enable[i] || (f_act == '0)) begin
                // Idle: keep tracking the input so the first period uses
                // whatever factor is present when the channel starts.
                cnt_nxt  = '0;
                clk_nxt  = 1'b0;
                run_nxt  = 1'b0;
                f_nxt    = f_in;
                mode_nxt = in_mode[i];
            end else if (in_sync) begin
                cnt_nxt  = '0;
                clk_nxt  = 1'b0;
                f_nxt    = f_in;
                mode_nxt = in_mode[i];
                run_nxt  = (f_in != '0);
            end else if (!run_q) begin
                // First enabled edge acts as the start point, exactly like a
                // sync edge: the first terminal count is f_act edges later.
                cnt_nxt = '0;
                clk_nxt = 1'b0;
                run_nxt = 1'b1;
            end else if (terminal) begin
                cnt_nxt = '0;
                clk_nxt = mode_act ? 1'b1 : ~clk_q;
                if (update_pt) begin
                    f_nxt    = f_in;
                    mode_nxt = in_mode[i];
                    if (f_in == '0) begin
                        clk_nxt = 1'b0;
                        run_nxt = 1'b0;
                    end
                end
            end else begin
                cnt_nxt = cnt + ONE;
                if (mode_act) begin
                    clk_nxt = 1'b0;
                end
            end
        end

        always_ff @(posedge in_clk or negedge in_rst_n) begin
            if (!in_rst_n) begin
                cnt      <= '0;
                f_act    <= '0;
                mode_act <= 1'b0;
                clk_q    <= 1'b0;
                run_q    <= 1'b0;
            end else begin
                cnt      <= cnt_nxt;
                f_act    <= f_nxt;
                mode_act <= mode_nxt;
                clk_q    <= clk_nxt;
                run_q    <= run_nxt;
            end
        end

        assign out_clk[i]    = clk_q;
        assign out_active[i] = run_q;
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// -----------------------------------------------------------------------------
// tb_multi_clock_divider
//
// Directed scenarios drive the divider while pushing the expected per-cycle
// outputs into a queue; a monitor pops one entry per cycle on the falling
// edge and compares. Expected waveforms are written per channel as strings:
//   '.' = out_clk 0, out_active 0
//   'l' = out_clk 0, out_active 1
//   'H' = out_clk 1, out_active 1
// -----------------------------------------------------------------------------
module tb_multi_clock_divider;

    localparam int CH = 4;
    localparam int W  = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            sync;
    logic [CH-1:0]   en;
    logic [CH-1:0]   mode;
    logic [CH*W-1:0] fac;
    logic [CH-1:0]   oclk;
    logic [CH-1:0]   oact;

    always #5 clk = ~clk;

    multi_clock_divider #(.CHANNELS(CH), .WIDTH(W)) dut (
        .in_clk            (clk),
        .in_rst_n          (rst_n),
        .in_sync           (sync),
        .in_enable         (en),
        .in_mode           (mode),
        .in_divider_factor (fac),
        .out_clk           (oclk),
        .out_active        (oact)
    );

    logic [7:0] q_exp[$];
    string      q_name[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    function automatic logic [1:0] code(input string s, input int i);
        byte c;
        c = 8'h2E;
        if (i < s.len()) c = s[i];
        case (c)
            "H":     return 2'b11;
            "l":     return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_f(input int ch, input logic [W-1:0] v);
        fac[ch*W +: W] = v;
    endtask

    // One entry per cycle: expected outputs after the coming rising edge.
    task automatic run_pat(input string name, input string p0, input string p1,
                           input string p2, input string p3);
        string p[4];
        int    n;
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        n = 0;
        for (int k = 0; k < 4; k++) if (p[k].len() > n) n = p[k].len();
        for (int i = 0; i < n; i++) begin
            logic [3:0] ec;
            logic [3:0] ea;
            for (int k = 0; k < 4; k++) begin
                logic [1:0] c;
                c     = code(p[k], i);
                ec[k] = c[1];
                ea[k] = c[0];
            end
            q_exp.push_back({ec, ea});
            q_name.push_back(name);
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    // Monitor
    logic [7:0] m_exp;
    string      m_name;
    initial begin
        forever begin
            @(negedge clk);
            if (q_exp.size() > 0) begin
                m_exp  = q_exp.pop_front();
                m_name = q_name.pop_front();
                n_cmp++;
                if ({oclk, oact} !== m_exp) begin
                    n_bad++;
                    $display("FAIL %s @%0t: out_clk=%b out_active=%b, required out_clk=%b out_active=%b",
                             m_name, $time, oclk, oact, m_exp[7:4], m_exp[3:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        rst_n = 1'b0;
        sync  = 1'b0;
        en    = '0;
        mode  = '0;
        fac   = '0;
        run_pat("reset", "..", "..", "..", "..");
        rst_n = 1'b1;

        // ch0 square, factor 3
        set_f(0, 3); mode[0] = 1'b0;
        run_pat("a_load", ".", ".", ".", ".");
        en[0] = 1'b1;
        run_pat("a_square3", "lllHHHlllHHHlll", "", "", "");
        en[0] = 1'b0;
        run_pat("a_off", ".", ".", ".", ".");

        // ch1 tick, factor 1 then 4
        set_f(1, 1); mode[1] = 1'b1;
        run_pat("b_load", ".", ".", ".", ".");
        en[1] = 1'b1;
        run_pat("b_tick1", "", "lHHHH", "", "");
        set_f(1, 4);
        run_pat("b_tick4", "", "HlllHlllH", "", "");
        en[1] = 1'b0;
        run_pat("b_off", ".", ".", ".", ".");

        // ch0 square 5, factor changed to 2 at cnt=1 of the high phase
        set_f(0, 5);
        run_pat("c_load", ".", ".", ".", ".");
        en[0] = 1'b1;
        run_pat("c_sq5", "lllllHH", "", "", "");
        set_f(0, 2);
        run_pat("c_switch", "HHHllHHllH", "", "", "");
        en[0] = 1'b0;
        run_pat("c_off", ".", ".", ".", ".");

        // ch2 square 3, ch3 tick 7, then sync
        set_f(2, 3); mode[2] = 1'b0;
        set_f(3, 7); mode[3] = 1'b1;
        run_pat("d_load", ".", ".", ".", ".");
        en[2] = 1'b1; en[3] = 1'b1;
        run_pat("d_run", "", "", "lllHH", "lllll");
        sync = 1'b1;
        run_pat("d_sync", "", "", "l", "l");
        sync = 1'b0;
        run_pat("d_after_sync", "", "", "llHH", "llll");

        // disable ch2 mid-high, factor 0 on ch3
        en[2] = 1'b0;
        set_f(3, 0);
        run_pat("e_off_zero", "", "", "....", "ll..");

        // maximum factor on ch3
        set_f(3, 32'hFFFF_FFFF); mode[3] = 1'b0;
        run_pat("g_maxf", "", "", "", ".lll");
        en[3] = 1'b0;

        // async reset while running
        set_f(0, 2); mode[0] = 1'b0;
        set_f(1, 1); mode[1] = 1'b1;
        run_pat("f_load", ".", ".", ".", ".");
        en[0] = 1'b1; en[1] = 1'b1;
        run_pat("f_run", "llHH", "lHHH", "", "");
        q_exp.push_back(8'h00);
        q_name.push_back("f_async_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        run_pat("f_in_reset", ".", ".", ".", ".");
        rst_n = 1'b1;
        run_pat("f_resume", ".llH", ".lHH", "", "");

        @(negedge clk);
        #1;
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: %0d entries left, required 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
